// File: rtl/bsg_dmc_ui_arbiter.sv
// bsg_dmc_ui_arbiter
// Round-robin arbiter that shares one bsg_dmc app_* port among num_req_p
// requesters. A grant is a command handshake, followed by the write-data
// burst for writes. Outstanding reads are tracked in an ID FIFO so that
// in-order read returns can be routed back to their owners.
//
// Optional feature macro: BSG_DMC_UI_ARB_REFRESH_STALL_EN
//   defined   : no new grant is made from IDLE while refresh_in_progress_i=1
//               (a CMD/WDATA already in flight completes normally)
//   undefined : refresh_in_progress_i is ignored
//
// Handshake semantics: on the requester side a command is offered with
// req_v_i and consumed by req_yumi_o (a consume pulse, so the requester may
// present its next command on the following cycle); the requester must hold
// req_v/cmd/addr stable until consumed. Write beats work the same way with
// wdata_v_i / wdata_yumi_o. Toward the controller, app_en_o / app_wdf_wren_o
// are valids and app_rdy_i / app_wdf_rdy_i are readies; a transfer happens on
// any cycle where both are high. Read returns have no back-pressure.
module bsg_dmc_ui_arbiter #(
    parameter int num_req_p         = 4,
    parameter int ui_addr_width_p   = 28,
    parameter int ui_data_width_p   = 32,
    parameter int ui_burst_length_p = 8,
    parameter int rd_tag_depth_p    = 4
) (
    input  logic                                          clk_i,
    input  logic                                          reset_n_i,
    input  logic [num_req_p-1:0]                          req_v_i,
    input  logic [num_req_p-1:0]                          req_cmd_i,
    input  logic [num_req_p*ui_addr_width_p-1:0]          req_addr_i,
    output logic [num_req_p-1:0]                          req_yumi_o,
    input  logic [num_req_p-1:0]                          wdata_v_i,
    input  logic [num_req_p*ui_data_width_p-1:0]          wdata_i,
    input  logic [num_req_p*(ui_data_width_p>>3)-1:0]     wmask_i,
    output logic [num_req_p-1:0]                          wdata_yumi_o,
    output logic [num_req_p-1:0]                          rd_v_o,
    output logic [ui_data_width_p-1:0]                    rd_data_o,
    output logic                                          rd_last_o,
    output logic [ui_addr_width_p-1:0]                    app_addr_o,
    output logic [2:0]                                    app_cmd_o,
    output logic                                          app_en_o,
    input  logic                                          app_rdy_i,
    output logic                                          app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]                    app_wdf_data_o,
    output logic [(ui_data_width_p>>3)-1:0]               app_wdf_mask_o,
    output logic                                          app_wdf_end_o,
    input  logic                                          app_wdf_rdy_i,
    input  logic                                          app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]                    app_rd_data_i,
    input  logic                                          app_rd_data_end_i,
    input  logic                                          init_calib_complete_i,
    input  logic                                          refresh_in_progress_i,
    output logic [1:0]                                    dbg_state_o,
    output logic [$clog2(rd_tag_depth_p):0]               dbg_rd_count_o
);

    localparam int lg_req_lp = $clog2(num_req_p);
    localparam int mask_w_lp = ui_data_width_p >> 3;
    localparam int beat_w_lp = (ui_burst_length_p > 1) ? $clog2(ui_burst_length_p) : 1;
    localparam int tag_w_lp  = (rd_tag_depth_p > 1) ? $clog2(rd_tag_depth_p) : 1;
    localparam int cnt_w_lp  = $clog2(rd_tag_depth_p) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2
    } state_e;

    state_e                 state_r, state_n;
    logic [lg_req_lp-1:0]   gid_r, gid_n;
    logic [lg_req_lp-1:0]   rr_ptr_r, rr_ptr_n;
    logic [beat_w_lp-1:0]   beat_cnt_r, beat_cnt_n;
    logic [num_req_p-1:0]   eligible;
    logic                   grant_v;
    logic [lg_req_lp-1:0]   grant_id;
    logic                   grant_ok;
    logic                   cmd_is_rd;
    logic                   last_beat;
    logic                   wren;

    logic [lg_req_lp-1:0]   tag_mem [rd_tag_depth_p];
    logic [tag_w_lp-1:0]    wr_ptr_r, rd_ptr_r;
    logic [cnt_w_lp-1:0]    count_r, count_n;
    logic                   full_r;
    logic                   empty;
    logic                   push;
    logic                   pop;

`ifdef BSG_DMC_UI_ARB_REFRESH_STALL_EN
    assign grant_ok = init_calib_complete_i & ~refresh_in_progress_i;
`else
    assign grant_ok = init_calib_complete_i;
    logic unused_refresh;
    assign unused_refresh = refresh_in_progress_i;
`endif

    assign cmd_is_rd      = req_cmd_i[gid_r];
    assign last_beat      = (beat_cnt_r == beat_w_lp'(ui_burst_length_p - 1));
    assign empty          = (count_r == '0);
    assign pop            = app_rd_data_valid_i & app_rd_data_end_i & ~empty;
    assign dbg_state_o    = state_r;
    assign dbg_rd_count_o = count_r;

    // Round-robin pick: first eligible requester at or after rr_ptr_r.
    // Reads are only eligible while the ID FIFO has room.
    always_comb begin
        int                   idx;
        logic [lg_req_lp-1:0] idx_l;
        eligible = req_v_i & (~req_cmd_i | {num_req_p{~full_r}});
        grant_v  = 1'b0;
        grant_id = '0;
        idx      = 0;
        idx_l    = '0;
        for (int k = num_req_p - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_r) + k;
            if (idx >= num_req_p) idx = idx - num_req_p;
            idx_l = lg_req_lp'(idx);
            if (eligible[idx_l]) begin
                grant_v  = 1'b1;
                grant_id = idx_l;
            end
        end
    end

    // Next-state and output decode for the IDLE -> CMD -> (WDATA) sequence.
    always_comb begin
        state_n        = state_r;
        gid_n          = gid_r;
        rr_ptr_n       = rr_ptr_r;
        beat_cnt_n     = beat_cnt_r;
        app_en_o       = 1'b0;
        wren           = 1'b0;
        app_wdf_end_o  = 1'b0;
        req_yumi_o     = '0;
        wdata_yumi_o   = '0;
        push           = 1'b0;
        app_addr_o     = req_addr_i[gid_r*ui_addr_width_p +: ui_addr_width_p];
        app_cmd_o      = cmd_is_rd ? 3'b001 : 3'b000;
        app_wdf_data_o = wdata_i[gid_r*ui_data_width_p +: ui_data_width_p];
        app_wdf_mask_o = wmask_i[gid_r*mask_w_lp +: mask_w_lp];
        case (state_r)
            IDLE: begin
                if (grant_ok && grant_v) begin
                    gid_n   = grant_id;
                    state_n = CMD;
                end
            end
            CMD: begin
                app_en_o = 1'b1;
                if (app_rdy_i) begin
                    req_yumi_o[gid_r] = 1'b1;
                    rr_ptr_n = (gid_r == lg_req_lp'(num_req_p - 1)) ? '0 : gid_r + 1'b1;
                    if (cmd_is_rd) begin
                        push    = 1'b1;
                        state_n = IDLE;
                    end else begin
                        beat_cnt_n = '0;
                        state_n    = WDATA;
                    end
                end
            end
            WDATA: begin
                wren          = wdata_v_i[gid_r];
                app_wdf_end_o = last_beat;
                if (wren && app_wdf_rdy_i) begin
                    wdata_yumi_o[gid_r] = 1'b1;
                    beat_cnt_n          = beat_cnt_r + 1'b1;
                    if (last_beat) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign app_wdf_wren_o = wren;

    // FSM, grant id, round-robin pointer and beat counter registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= IDLE;
            gid_r      <= '0;
            rr_ptr_r   <= '0;
            beat_cnt_r <= '0;
        end else begin
            state_r    <= state_n;
            gid_r      <= gid_n;
            rr_ptr_r   <= rr_ptr_n;
            beat_cnt_r <= beat_cnt_n;
        end
    end

    // Occupancy update; push and pop together leave the count unchanged.
    always_comb begin
        count_n = count_r;
        if (push && !pop)      count_n = count_r + 1'b1;
        else if (pop && !push) count_n = count_r - 1'b1;
    end

    // ID FIFO pointers, count and registered full flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
            count_r <= count_n;
            full_r  <= (count_n == cnt_w_lp'(rd_tag_depth_p));
        end
    end

    // ID FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push) tag_mem[wr_ptr_r] <= gid_r;
    end

    // Read return routing to the owner at the FIFO head.
    always_comb begin
        rd_v_o    = '0;
        rd_data_o = app_rd_data_i;
        rd_last_o = app_rd_data_valid_i & app_rd_data_end_i & ~empty;
        if (app_rd_data_valid_i && !empty) rd_v_o[tag_mem[rd_ptr_r]] = 1'b1;
    end

`ifndef SYNTHESIS
    // Protocol checks: stable request during CMD, no orphan read data.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(state_r == CMD && !req_v_i[gid_r]))
                else $error("requester %0d dropped req_v during CMD", gid_r);
            assert (!(app_rd_data_valid_i && empty))
                else $error("read data returned with no outstanding read");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_dmc_ui_arbiter.sv
// Directed bench for bsg_dmc_ui_arbiter: grant rotation, write bursts with
// back-pressure, read-return routing, FIFO full / simultaneous push+pop,
// asynchronous reset abort and refresh handling.
module tb_bsg_dmc_ui_arbiter;

    localparam int N = 4;
    localparam int A = 28;
    localparam int D = 32;
    localparam int M = D >> 3;

    logic           clk_i = 1'b0;
    logic           reset_n_i;
    logic [N-1:0]   req_v_i, req_cmd_i, req_yumi_o;
    logic [N*A-1:0] req_addr_i;
    logic [N-1:0]   wdata_v_i, wdata_yumi_o, rd_v_o;
    logic [N*D-1:0] wdata_i;
    logic [N*M-1:0] wmask_i;
    logic [D-1:0]   rd_data_o, app_wdf_data_o, app_rd_data_i;
    logic           rd_last_o, app_en_o, app_rdy_i, app_wdf_wren_o, app_wdf_end_o;
    logic [A-1:0]   app_addr_o;
    logic [2:0]     app_cmd_o;
    logic [M-1:0]   app_wdf_mask_o;
    logic           app_wdf_rdy_i, app_rd_data_valid_i, app_rd_data_end_i;
    logic           init_calib_complete_i, refresh_in_progress_i;
    logic [1:0]     dbg_state_o;
    logic [2:0]     dbg_rd_count_o;

    int checks = 0;
    int errors = 0;

    bsg_dmc_ui_arbiter dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .req_v_i(req_v_i), .req_cmd_i(req_cmd_i), .req_addr_i(req_addr_i),
        .req_yumi_o(req_yumi_o),
        .wdata_v_i(wdata_v_i), .wdata_i(wdata_i), .wmask_i(wmask_i),
        .wdata_yumi_o(wdata_yumi_o),
        .rd_v_o(rd_v_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
        .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o),
        .app_rdy_i(app_rdy_i),
        .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_data_o(app_wdf_data_o),
        .app_wdf_mask_o(app_wdf_mask_o), .app_wdf_end_o(app_wdf_end_o),
        .app_wdf_rdy_i(app_wdf_rdy_i),
        .app_rd_data_valid_i(app_rd_data_valid_i), .app_rd_data_i(app_rd_data_i),
        .app_rd_data_end_i(app_rd_data_end_i),
        .init_calib_complete_i(init_calib_complete_i),
        .refresh_in_progress_i(refresh_in_progress_i),
        .dbg_state_o(dbg_state_o), .dbg_rd_count_o(dbg_rd_count_o)
    );

    // Clock and watchdog.
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sample point: 1 time unit after the falling edge.
    task automatic cyc();
        @(negedge clk_i);
        #1;
    endtask

    // Wait for a command consume; returns id (-1 on timeout), latency in
    // cycles, and the address/cmd seen, then steps one more cycle so the
    // caller may change req_* without violating the hold rule.
    task automatic wait_cmd(output int id, output int lat, output logic [A-1:0] addr,
                            output logic [2:0] cmd);
        id = -1; lat = 0; addr = '0; cmd = '0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (req_yumi_o != '0) begin
                lat  = k;
                addr = app_addr_o;
                cmd  = app_cmd_o;
                for (int j = 0; j < N; j++) if (req_yumi_o[j]) id = j;
                break;
            end
        end
        cyc();
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 40; k++) begin
            if (dbg_state_o == 2'd0) break;
            cyc();
        end
        check("wait_idle", dbg_state_o, 2'd0);
    endtask

    // Drive a write burst from requester id (others offer junk data too);
    // stops after stop_at accepted beats.
    task automatic run_wburst(input int id, input logic [D-1:0] base, input bit toggle,
                              input int stop_at, output int beats, output int ends);
        int k;
        beats = 0; ends = 0; k = 0;
        wdata_v_i = '1;
        for (int j = 0; j < N; j++) wdata_i[j*D +: D] = 32'hDEAD_0000 + j;
        while (beats < stop_at && k < 60) begin
            wdata_i[id*D +: D] = base + beats;
            wmask_i[id*M +: M] = beats[3:0];
            app_wdf_rdy_i = toggle ? ~k[0] : 1'b1;
            #1;
            if (app_wdf_wren_o && app_wdf_rdy_i) begin
                check("wdata", app_wdf_data_o, base + beats);
                check("wmask", app_wdf_mask_o, beats[3:0]);
                check("wdata_yumi", wdata_yumi_o, 64'd1 << id);
                check("wend", app_wdf_end_o, beats == 7);
                if (app_wdf_end_o) ends++;
                beats++;
            end
            k++;
            cyc();
        end
        wdata_v_i = '0;
        app_wdf_rdy_i = 1'b1;
    endtask

    task automatic rd_burst(input int owner, input int n, input logic [D-1:0] base);
        int lasts = 0;
        for (int b = 0; b < n; b++) begin
            app_rd_data_valid_i = 1'b1;
            app_rd_data_i       = base + b;
            app_rd_data_end_i   = (b == n - 1);
            #1;
            check("rd_v", rd_v_o, 64'd1 << owner);
            check("rd_data", rd_data_o, base + b);
            if (rd_last_o) lasts++;
            cyc();
        end
        app_rd_data_valid_i = 1'b0;
        app_rd_data_end_i   = 1'b0;
        check("rd_last_cnt", lasts, 1);
    endtask

    // Directed sequence.
    initial begin
        int id, lat, beats, ends, seen;
        logic [A-1:0] addr;
        logic [2:0]   cmd;

        reset_n_i = 1'b1;
        req_v_i = '0; req_cmd_i = '0; req_addr_i = '0;
        wdata_v_i = '0; wdata_i = '0; wmask_i = '0;
        app_rdy_i = 1'b0; app_wdf_rdy_i = 1'b0;
        app_rd_data_valid_i = 1'b0; app_rd_data_i = '0; app_rd_data_end_i = 1'b0;
        init_calib_complete_i = 1'b0; refresh_in_progress_i = 1'b0;
        for (int j = 0; j < N; j++) req_addr_i[j*A +: A] = 28'h10 * (j + 1);

        // 1: reset with all requests valid, then rotation 0,1,2,3,0
        #2 reset_n_i = 1'b0;
        req_v_i = 4'b1111;
        cyc(); cyc();
        check("rst_outputs",
              {app_en_o, app_wdf_wren_o, app_wdf_end_o, req_yumi_o, wdata_yumi_o, rd_v_o, rd_last_o}, '0);
        check("rst_state", dbg_state_o, 2'd0);
        check("rst_count", dbg_rd_count_o, 3'd0);
        reset_n_i = 1'b1; init_calib_complete_i = 1'b1;
        app_rdy_i = 1'b1; app_wdf_rdy_i = 1'b1; wdata_v_i = '1;
        for (int g = 0; g < 5; g++) begin
            wait_cmd(id, lat, addr, cmd);
            check("t1_grant", id, g % N);
            check("t1_addr", addr, 28'h10 * ((g % N) + 1));
            if (g == 0) check("t1_latency", lat, 1);
        end
        req_v_i = '0;
        wait_idle();
        wdata_v_i = '0;

        // 2: 8-beat write from req1 with toggling app_wdf_rdy
        req_addr_i[1*A +: A] = 28'h100;
        req_v_i = 4'b0010; req_cmd_i = 4'b0000;
        wait_cmd(id, lat, addr, cmd);
        check("t2_grant", id, 1);
        check("t2_addr", addr, 28'h100);
        check("t2_cmd", cmd, 3'b000);
        check("t2_latency", lat, 1);
        req_v_i = '0;
        run_wburst(1, 32'hA0, 1'b1, 8, beats, ends);
        check("t2_beats", beats, 8);
        check("t2_ends", ends, 1);
        check("t2_back_idle", dbg_state_o, 2'd0);
        cyc();
        check("t2_no_extra_wren", app_wdf_wren_o, 1'b0);

        // 3: reads from req2, req0, req3 then three returned bursts
        req_cmd_i = 4'b1111;
        req_v_i = 4'b0100;
        wait_cmd(id, lat, addr, cmd);
        check("t3_grant_a", id, 2);
        check("t3_cmd", cmd, 3'b001);
        req_v_i = 4'b0001;
        wait_cmd(id, lat, addr, cmd);
        check("t3_grant_b", id, 0);
        req_v_i = 4'b1000;
        wait_cmd(id, lat, addr, cmd);
        check("t3_grant_c", id, 3);
        req_v_i = '0;
        check("t3_count", dbg_rd_count_o, 3'd3);
        rd_burst(2, 8, 32'h2000);
        rd_burst(0, 8, 32'h3000);
        rd_burst(3, 8, 32'h4000);
        check("t3_drained", dbg_rd_count_o, 3'd0);

        // 4: fill FIFO, write passes blocked read, pop+push same cycle
        req_v_i = 4'b1111; req_cmd_i = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            wait_cmd(id, lat, addr, cmd);
            check("t4_fill_grant", id, g);
        end
        check("t4_full_count", dbg_rd_count_o, 3'd4);
        req_addr_i[0*A +: A] = 28'h400;
        req_addr_i[1*A +: A] = 28'h500;
        req_v_i = 4'b0011; req_cmd_i = 4'b0001;
        wait_cmd(id, lat, addr, cmd);
        check("t4_write_grant", id, 1);
        check("t4_write_cmd", cmd, 3'b000);
        req_v_i = 4'b0001;
        run_wburst(1, 32'hB0, 1'b0, 8, beats, ends);
        check("t4_beats", beats, 8);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (app_en_o) seen++;
            cyc();
        end
        check("t4_read_held", seen, 0);
        app_rdy_i = 1'b0;
        rd_burst(0, 8, 32'h5000);
        check("t4_after_pop_count", dbg_rd_count_o, 3'd3);
        check("t4_idle_after_pop", app_en_o, 1'b0);
        cyc();
        check("t4_cmd_en", app_en_o, 1'b1);
        check("t4_cmd_addr", app_addr_o, 28'h400);
        check("t4_cmd_rd", app_cmd_o, 3'b001);
        check("t4_no_yumi", req_yumi_o, 4'b0000);
        app_rd_data_valid_i = 1'b1; app_rd_data_end_i = 1'b1;
        app_rd_data_i = 32'h6000; app_rdy_i = 1'b1;
        #1;
        check("t4_push_yumi", req_yumi_o, 4'b0001);
        check("t4_pop_owner", rd_v_o, 4'b0010);
        cyc();
        app_rd_data_valid_i = 1'b0; app_rd_data_end_i = 1'b0;
        req_v_i = '0;
        check("t4_pushpop_count", dbg_rd_count_o, 3'd3);
        rd_burst(2, 1, 32'h7000);
        rd_burst(3, 1, 32'h7100);
        rd_burst(0, 1, 32'h7200);
        check("t4_drained", dbg_rd_count_o, 3'd0);

        // 5: reset mid-WDATA at beat 3, then a fresh full burst
        req_addr_i[1*A +: A] = 28'h200;
        req_v_i = 4'b0010; req_cmd_i = 4'b0000;
        wait_cmd(id, lat, addr, cmd);
        check("t5_grant", id, 1);
        req_v_i = '0;
        run_wburst(1, 32'hE0, 1'b0, 3, beats, ends);
        check("t5_partial", beats, 3);
        wdata_v_i[1] = 1'b1;
        wdata_i[1*D +: D] = 32'hE3;
        #1;
        check("t5_pre_rst_wren", app_wdf_wren_o, 1'b1);
        reset_n_i = 1'b0;
        #1;
        check("t5_rst_outputs",
              {app_en_o, app_wdf_wren_o, app_wdf_end_o, req_yumi_o, wdata_yumi_o}, '0);
        check("t5_rst_state", dbg_state_o, 2'd0);
        wdata_v_i = '0;
        cyc();
        reset_n_i = 1'b1;
        req_addr_i[1*A +: A] = 28'h300;
        req_v_i = 4'b0010;
        wait_cmd(id, lat, addr, cmd);
        check("t5_fresh_grant", id, 1);
        check("t5_fresh_addr", addr, 28'h300);
        check("t5_fresh_latency", lat, 1);
        req_v_i = '0;
        run_wburst(1, 32'hF0, 1'b1, 8, beats, ends);
        check("t5_beats", beats, 8);
        check("t5_ends", ends, 1);

        // 6: refresh in progress with a pending read
        req_cmd_i = 4'b0100; req_v_i = 4'b0100;
        refresh_in_progress_i = 1'b1;
`ifdef BSG_DMC_UI_ARB_REFRESH_STALL_EN
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (app_en_o) seen++;
            cyc();
        end
        check("t6_stalled", seen, 0);
        refresh_in_progress_i = 1'b0;
        cyc();
        check("t6_first_grant_en", app_en_o, 1'b1);
        check("t6_first_grant_yumi", req_yumi_o, 4'b0100);
        cyc();
`else
        wait_cmd(id, lat, addr, cmd);
        check("t6_grant_during_refresh", id, 2);
        check("t6_latency", lat, 1);
        refresh_in_progress_i = 1'b0;
`endif
        req_v_i = '0;
        rd_burst(2, 1, 32'h8000);
        check("t6_drained", dbg_rd_count_o, 3'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
